id_issue_buffer: RTL and testbench

- Parametrised decode-to-issue buffer; successor to the single-entry ID/issue pipeline register.
- Sits between the decoder output and the issue stage. Holds up to Depth decoded scoreboard entries, each with a control-flow flag, in program order.
- Adds three things: configurable depth, an optional fall-through path when empty, and a cap on in-flight control-flow instructions.
- Depth=1, FallThrough=0, MaxCtrlFlow=0 is cycle-identical to the legacy single register.

---
 rtl/id_issue_buffer_pkg.sv | 23 ++
 rtl/id_issue_buffer_chk.sv | 29 ++
 rtl/id_issue_buffer.sv | 156 +++++++++++++++
 tb/tb_id_issue_buffer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_issue_buffer_pkg.sv
// Shared types for the decode-to-issue buffer: the decoded scoreboard entry,
// the stored buffer slot and the core configuration field that sizes it.
package id_issue_buffer_pkg;

    // Decoded instruction as handed from the decoder to the issue stage.
    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  op;
        logic [4:0]  rd;
    } scoreboard_entry_t;

    // One buffer slot: the decoded entry plus its control-flow flag.
    typedef struct packed {
        scoreboard_entry_t sbe;
        logic              is_ctrl_flow;
    } id_buf_entry_t;

    // Core configuration; IdBufDepth sets the Depth of the ID/issue buffer.
    typedef struct packed {
        logic [31:0] IdBufDepth;
    } ariane_cfg_t;

endpackage

// File: rtl/id_issue_buffer_chk.sv
// Invariant checker for id_issue_buffer: occupancy bounds and the
// control-flow cap. Contains only assertions, no functional logic.
module id_issue_buffer_chk #(
    parameter int unsigned Depth       = 2,
    parameter int unsigned MaxCtrlFlow = 0
) (
    input logic                       clk_i,
    input logic                       rst_ni,
    input logic [$clog2(Depth+1)-1:0] usage_i,
    input logic [$clog2(Depth+1)-1:0] cf_cnt_i
);

    if (Depth == 32'd0) begin : g_depth_check
        $fatal(1, "id_issue_buffer: Depth must be at least 1");
    end

    // Occupancy never exceeds the number of slots.
    a_usage_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        32'(usage_i) <= Depth);

    // Control-flow entries are a subset of the held entries.
    a_cf_le_usage: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cf_cnt_i <= usage_i);

    // The in-flight control-flow cap is honoured when enabled.
    a_cf_cap: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (MaxCtrlFlow == 32'd0) || (32'(cf_cnt_i) <= MaxCtrlFlow));

endmodule

// File: rtl/id_issue_buffer.sv
// Decode-to-issue buffer. Holds up to Depth decoded entries in program order
// in a circular array, optionally presents the input directly when empty
// (FallThrough) and limits the number of held control-flow entries
// (MaxCtrlFlow, 0 = unlimited). Depth=1/FallThrough=0/MaxCtrlFlow=0 behaves
// exactly like the former single ID/issue pipeline register.
module id_issue_buffer
    import id_issue_buffer_pkg::*;
#(
    parameter int unsigned Depth       = 2,
    parameter bit          FallThrough = 1'b0,
    parameter int unsigned MaxCtrlFlow = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  scoreboard_entry_t          decoded_entry_i,
    input  logic                       decoded_is_ctrl_flow_i,
    input  logic                       decoded_valid_i,
    output logic                       decoded_ready_o,
    output scoreboard_entry_t          issue_entry_o,
    output logic                       issue_entry_valid_o,
    output logic                       is_ctrl_flow_o,
    input  logic                       issue_instr_ack_i,
    output logic [$clog2(Depth+1)-1:0] usage_o,
    output logic [$clog2(Depth+1)-1:0] ctrl_flow_cnt_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned PtrW = (Depth > 32'd1) ? $clog2(Depth) : 1;

    id_buf_entry_t   mem_q [Depth];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] cf_cnt_q, cf_cnt_d;

    id_buf_entry_t   head_s;
    logic            stored_valid_s;
    logic            pop_stored_s;
    logic            head_cf_pop_s;
    logic            cf_ok_s;
    logic            ft_active_s;
    logic            issue_valid_s;
    logic            push_s;
    logic            pop_ft_s;
    logic            push_write_s;
    logic            push_cf_s;

    // Advance a pointer, wrapping from Depth-1 back to slot 0.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        logic [PtrW-1:0] res;
        if (ptr == PtrW'(Depth - 32'd1)) begin
            res = {PtrW{1'b0}};
        end else begin
            res = ptr + PtrW'(1'b1);
        end
        return res;
    endfunction

    // Handshake decode: pop, control-flow admission, ready and push.
    always_comb begin
        head_s         = mem_q[rd_ptr_q];
        stored_valid_s = (count_q != {CntW{1'b0}});
        // A stored head is always presented, so an ack pops it directly;
        // this keeps cf_ok free of any loop through the fall-through path.
        pop_stored_s   = issue_instr_ack_i && stored_valid_s;
        head_cf_pop_s  = pop_stored_s && head_s.is_ctrl_flow;

        if ((MaxCtrlFlow == 32'd0) || !decoded_is_ctrl_flow_i) begin
            cf_ok_s = 1'b1;
        end else begin
            cf_ok_s = ((32'(cf_cnt_q) - 32'(head_cf_pop_s)) < MaxCtrlFlow);
        end

        ft_active_s = FallThrough && !stored_valid_s;

        if (ft_active_s) begin
            issue_valid_s = decoded_valid_i && cf_ok_s && !flush_i;
        end else begin
            issue_valid_s = stored_valid_s;
        end

        decoded_ready_o = decoded_valid_i
                          && ((32'(count_q) < Depth) || pop_stored_s)
                          && cf_ok_s;
        push_s          = decoded_ready_o && !flush_i;

        // An entry that falls through and is acked at once is never stored.
        pop_ft_s     = ft_active_s && issue_instr_ack_i && issue_valid_s;
        push_write_s = push_s && !pop_ft_s;
        push_cf_s    = push_write_s && decoded_is_ctrl_flow_i;
    end

    // Issue-side outputs: the stored head, or the input entry when falling through.
    always_comb begin
        issue_entry_valid_o = issue_valid_s;
        if (ft_active_s) begin
            issue_entry_o  = decoded_entry_i;
            is_ctrl_flow_o = decoded_is_ctrl_flow_i;
        end else begin
            issue_entry_o  = head_s.sbe;
            is_ctrl_flow_o = head_s.is_ctrl_flow;
        end
        usage_o         = count_q;
        ctrl_flow_cnt_o = cf_cnt_q;
    end

    // Next-state for pointers and counters; flush empties the buffer.
    always_comb begin
        if (flush_i) begin
            rd_ptr_d = {PtrW{1'b0}};
            wr_ptr_d = {PtrW{1'b0}};
            count_d  = {CntW{1'b0}};
            cf_cnt_d = {CntW{1'b0}};
        end else begin
            rd_ptr_d = pop_stored_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
            wr_ptr_d = push_write_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
            count_d  = count_q + CntW'(push_write_s) - CntW'(pop_stored_s);
            cf_cnt_d = cf_cnt_q + CntW'(push_cf_s) - CntW'(head_cf_pop_s);
        end
    end

    // State registers and slot storage; slots are only written on push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= {PtrW{1'b0}};
            wr_ptr_q <= {PtrW{1'b0}};
            count_q  <= {CntW{1'b0}};
            cf_cnt_q <= {CntW{1'b0}};
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            cf_cnt_q <= cf_cnt_d;
            if (push_write_s) begin
                mem_q[wr_ptr_q] <= '{sbe: decoded_entry_i, is_ctrl_flow: decoded_is_ctrl_flow_i};
            end else begin
                mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
            end
        end
    end

    id_issue_buffer_chk #(
        .Depth       (Depth),
        .MaxCtrlFlow (MaxCtrlFlow)
    ) u_chk (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .usage_i  (count_q),
        .cf_cnt_i (cf_cnt_q)
    );

endmodule

// File: tb/tb_id_issue_buffer.sv
// Scoreboard bench for id_issue_buffer. Three instances share one input
// stream: u0 Depth=2 with a control-flow cap of 1, u1 the legacy Depth=1
// register, u2 Depth=3 with fall-through. Each has a queue-based reference.
module tb_id_issue_buffer;
    import id_issue_buffer_pkg::*;

    localparam int DEP   [3] = '{2, 1, 3};
    localparam int FT    [3] = '{0, 0, 1};
    localparam int MAXCF [3] = '{1, 0, 0};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              dvalid;
    logic              dcf;
    logic              ack;
    scoreboard_entry_t dent;

    logic              rdy0, rdy1, rdy2;
    logic              vld0, vld1, vld2;
    logic              cf0, cf1, cf2;
    scoreboard_entry_t ent0, ent1, ent2;
    logic [1:0]        use0, use2, cc0, cc2;
    logic [0:0]        use1, cc1;

    logic [63:0] rdy_a [3];
    logic [63:0] vld_a [3];
    logic [63:0] cf_a  [3];
    logic [63:0] ent_a [3];
    logic [63:0] use_a [3];
    logic [63:0] cc_a  [3];

    logic [63:0] exp_rdy [3];
    logic [63:0] exp_vld [3];
    logic [63:0] exp_use [3];
    logic [63:0] exp_cc  [3];

    id_buf_entry_t sb [3][$];
    id_buf_entry_t mon_e;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_issue_buffer #(.Depth(2), .FallThrough(1'b0), .MaxCtrlFlow(1)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .decoded_entry_i(dent),
        .decoded_is_ctrl_flow_i(dcf), .decoded_valid_i(dvalid), .decoded_ready_o(rdy0),
        .issue_entry_o(ent0), .issue_entry_valid_o(vld0), .is_ctrl_flow_o(cf0),
        .issue_instr_ack_i(ack), .usage_o(use0), .ctrl_flow_cnt_o(cc0));

    id_issue_buffer #(.Depth(1), .FallThrough(1'b0), .MaxCtrlFlow(0)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .decoded_entry_i(dent),
        .decoded_is_ctrl_flow_i(dcf), .decoded_valid_i(dvalid), .decoded_ready_o(rdy1),
        .issue_entry_o(ent1), .issue_entry_valid_o(vld1), .is_ctrl_flow_o(cf1),
        .issue_instr_ack_i(ack), .usage_o(use1), .ctrl_flow_cnt_o(cc1));

    id_issue_buffer #(.Depth(3), .FallThrough(1'b1), .MaxCtrlFlow(0)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .decoded_entry_i(dent),
        .decoded_is_ctrl_flow_i(dcf), .decoded_valid_i(dvalid), .decoded_ready_o(rdy2),
        .issue_entry_o(ent2), .issue_entry_valid_o(vld2), .is_ctrl_flow_o(cf2),
        .issue_instr_ack_i(ack), .usage_o(use2), .ctrl_flow_cnt_o(cc2));

    // Gather instance outputs into uniform 64-bit arrays.
    always_comb begin
        rdy_a[0] = 64'(rdy0); rdy_a[1] = 64'(rdy1); rdy_a[2] = 64'(rdy2);
        vld_a[0] = 64'(vld0); vld_a[1] = 64'(vld1); vld_a[2] = 64'(vld2);
        cf_a[0]  = 64'(cf0);  cf_a[1]  = 64'(cf1);  cf_a[2]  = 64'(cf2);
        ent_a[0] = 64'(ent0); ent_a[1] = 64'(ent1); ent_a[2] = 64'(ent2);
        use_a[0] = 64'(use0); use_a[1] = 64'(use1); use_a[2] = 64'(use2);
        cc_a[0]  = 64'(cc0);  cc_a[1]  = 64'(cc1);  cc_a[2]  = 64'(cc2);
    end

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s inst%0d @%0t: got %0h expected %0h", nm, k, $time, act, expv);
        end
    endtask

    // Monitor: every handshake on the issue side pops and checks the expected head.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (vld_a[k][0] && ack) begin
                    if (sb[k].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL issue_unexpected inst%0d @%0t: got entry %0h expected none", k, $time, ent_a[k]);
                    end else begin
                        mon_e = sb[k].pop_front();
                        chk("issue_entry", k, ent_a[k], 64'(mon_e.sbe));
                        chk("issue_cf", k, cf_a[k], 64'(mon_e.is_ctrl_flow));
                    end
                end
            end
        end
    end

    // One clock cycle: drive inputs, predict from the reference queues, check mid-cycle.
    task automatic cyc(input logic v, input logic c, input logic a, input logic f);
        int n, ncf, hcf_pop;
        logic hcf, pst, cfok, ivl, rdy;
        id_buf_entry_t e;
        @(posedge clk);
        #1;
        dvalid  = v;
        dcf     = c;
        ack     = a;
        flush   = f;
        dent.pc = $urandom();
        dent.op = 8'($urandom());
        dent.rd = 5'($urandom());
        for (int k = 0; k < 3; k++) begin
            n   = sb[k].size();
            ncf = 0;
            for (int j = 0; j < n; j++) begin
                if (sb[k][j].is_ctrl_flow) ncf++;
            end
            hcf     = (n > 0) && sb[k][0].is_ctrl_flow;
            pst     = a && (n > 0);
            hcf_pop = (pst && hcf) ? 1 : 0;
            cfok    = (MAXCF[k] == 0) || !c || ((ncf - hcf_pop) < MAXCF[k]);
            ivl     = (n > 0) || ((FT[k] != 0) && v && cfok && !f);
            rdy     = v && ((n < DEP[k]) || (a && ivl)) && cfok;
            exp_rdy[k] = 64'(rdy);
            exp_vld[k] = 64'(ivl);
            exp_use[k] = 64'(n);
            exp_cc[k]  = 64'(ncf);
            if (rdy && !f) begin
                e.sbe          = dent;
                e.is_ctrl_flow = c;
                sb[k].push_back(e);
            end
        end
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("ready", k, rdy_a[k], exp_rdy[k]);
            chk("valid", k, vld_a[k], exp_vld[k]);
            chk("usage", k, use_a[k], exp_use[k]);
            chk("cf_cnt", k, cc_a[k], exp_cc[k]);
            if ((FT[k] != 0) && (exp_use[k] == 64'd0)) begin
                chk("ft_entry", k, ent_a[k], 64'(dent));
            end
            if (f) sb[k].delete();
        end
    endtask

    task automatic check_reset_state();
        for (int k = 0; k < 3; k++) begin
            chk("rst_usage", k, use_a[k], 64'd0);
            chk("rst_cf_cnt", k, cc_a[k], 64'd0);
            chk("rst_valid", k, vld_a[k], 64'd0);
            if (FT[k] == 0) chk("rst_entry", k, ent_a[k], 64'd0);
            else            chk("rst_entry_ft", k, ent_a[k], 64'(dent));
            sb[k].delete();
        end
    endtask

    initial begin
        rst_n  = 1'b1;
        flush  = 1'b0;
        dvalid = 1'b0;
        dcf    = 1'b0;
        ack    = 1'b0;
        dent   = '0;
        #1 rst_n = 1'b0;
        #1 check_reset_state();
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Fill: A, B (control flow), C rejected on the two-entry instance.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        // Full with ack: space freed by the pop is used in the same cycle.
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        // Flush together with push D and ack; D must never show up.
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        // Control-flow cap: cf head, cf push rejected, then accepted with ack.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        // Fall-through: empty, entry acked in the same cycle.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        // Wrap: pushes with alternating acks walk the pointers around.
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'(i % 3 == 0), 1'(i % 2), 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Random stream.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
        end

        // Reset in the middle of traffic returns immediately to the reset state.
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        dvalid = 1'b0;
        ack    = 1'b0;
        flush  = 1'b0;
        #1 check_reset_state();
        @(negedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 200; i++) begin
            cyc(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 4),
                1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 29) == 0));
        end
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
